// File: rtl/swa_weight_ctrl.sv
// Weighted-round-robin budget tracker for the VC/switch allocator: counts per-port and
// per-IVC grants each round, exposes "budget consumed" masks and restarts rounds.
module swa_weight_ctrl #(
    parameter int P           = 5,
    parameter int V           = 4,
    parameter int WEIGHTw     = 4,
    parameter int INIT_WEIGHT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [P*V-1:0]         ivc_request_all,
    input  logic [P*V-1:0]         ivc_num_getting_sw_grant,
    input  logic [P*V-1:0]         granted_flit_is_tail_all,
    input  logic                   cfg_wr,
    input  logic [$clog2(P)-1:0]   cfg_port,
    input  logic [WEIGHTw-1:0]     cfg_weight,
    output logic [P-1:0]           iport_weight_is_consumed_all,
    output logic [P*V-1:0]         vc_weight_is_consumed_all,
    output logic                   round_start
);

    localparam int PV = P * V;
    localparam int PW = $clog2(P);
    localparam logic [WEIGHTw-1:0] W_INIT = WEIGHTw'(INIT_WEIGHT);
    localparam logic [WEIGHTw-1:0] W_ONE  = WEIGHTw'(1);

    logic [WEIGHTw-1:0] w_act_reg  [P];
    logic [WEIGHTw-1:0] w_act_next [P];
    logic [WEIGHTw-1:0] w_shd_reg  [P];
    logic [WEIGHTw-1:0] w_shd_next [P];
    logic [WEIGHTw-1:0] pcnt_reg   [P];
    logic [WEIGHTw-1:0] pcnt_next  [P];
    logic [WEIGHTw-1:0] vcnt_reg   [PV];
    logic [WEIGHTw-1:0] vcnt_next  [PV];

    // Weight and count base that apply to this cycle's grant (new round on restart)
    logic [WEIGHTw-1:0] w_round    [P];
    logic [WEIGHTw-1:0] pcnt_base  [P];
    logic [WEIGHTw-1:0] vcnt_base  [PV];

    logic [P-1:0]  port_flag_reg;
    logic [P-1:0]  port_flag_next;
    logic [PV-1:0] vc_flag_reg;
    logic [PV-1:0] vc_flag_next;
    logic [P-1:0]  port_done;
    logic [P-1:0]  port_req;
    logic [P-1:0]  port_grant;
    logic [P-1:0]  wr_hit;

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_port
            localparam logic [PW-1:0] PORT_ID = PW'(gi);

            assign port_req[gi]   = |ivc_request_all[gi*V +: V];
            assign port_grant[gi] = |ivc_num_getting_sw_grant[gi*V +: V];
            assign port_done[gi]  = port_flag_reg[gi] | ~port_req[gi];

            // Out-of-range port indices never match, so such writes fall away
            assign wr_hit[gi]     = cfg_wr && (cfg_port == PORT_ID);
            assign w_shd_next[gi] = !wr_hit[gi] ? w_shd_reg[gi] :
                                    (cfg_weight == '0) ? W_ONE : cfg_weight;
            assign w_act_next[gi] = round_start ? w_shd_reg[gi] : w_act_reg[gi];

            assign w_round[gi]    = round_start ? w_shd_reg[gi] : w_act_reg[gi];
            assign pcnt_base[gi]  = round_start ? '0 : pcnt_reg[gi];
            assign pcnt_next[gi]  = (port_grant[gi] && (pcnt_base[gi] < w_round[gi])) ?
                                    pcnt_base[gi] + W_ONE : pcnt_base[gi];
            assign port_flag_next[gi] = (pcnt_next[gi] == w_round[gi]);
        end

        for (genvar gi = 0; gi < PV; gi++) begin : g_ivc
            localparam int PI = gi / V;

            assign vcnt_base[gi] = round_start ? '0 : vcnt_reg[gi];
            assign vcnt_next[gi] = (ivc_num_getting_sw_grant[gi] && (vcnt_base[gi] < w_round[PI])) ?
                                   vcnt_base[gi] + W_ONE : vcnt_base[gi];
            // A tail ends the IVC's turn even if budget remains
            assign vc_flag_next[gi] = (vc_flag_reg[gi] & ~round_start) |
                                      (ivc_num_getting_sw_grant[gi] &
                                       ((vcnt_next[gi] == w_round[PI]) | granted_flit_is_tail_all[gi]));
        end
    endgenerate

    // An idle router must not spin through empty rounds, hence the request term
    assign round_start = (&port_done) && (|port_flag_reg) && (|ivc_request_all);

    assign iport_weight_is_consumed_all = port_flag_reg;
    assign vc_weight_is_consumed_all    = vc_flag_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < P; p++) begin
                w_act_reg[p] <= W_INIT;
                w_shd_reg[p] <= W_INIT;
                pcnt_reg[p]  <= '0;
            end
            for (int i = 0; i < PV; i++) begin
                vcnt_reg[i] <= '0;
            end
            port_flag_reg <= '0;
            vc_flag_reg   <= '0;
        end else begin
            w_act_reg     <= w_act_next;
            w_shd_reg     <= w_shd_next;
            pcnt_reg      <= pcnt_next;
            vcnt_reg      <= vcnt_next;
            port_flag_reg <= port_flag_next;
            vc_flag_reg   <= vc_flag_next;
        end
    end

endmodule

// File: tb/tb_swa_weight_ctrl.sv
// Directed bench for swa_weight_ctrl: one task per scenario, hand-computed expectations.
module tb_swa_weight_ctrl;

    localparam int P  = 5;
    localparam int V  = 4;
    localparam int PV = P * V;

    localparam logic [PV-1:0] B0 = 20'h00001;
    localparam logic [PV-1:0] B4 = 20'h00010;
    localparam logic [PV-1:0] B5 = 20'h00020;
    localparam logic [PV-1:0] B8 = 20'h00100;

    logic          clk = 1'b0;
    logic          reset;
    logic [PV-1:0] req;
    logic [PV-1:0] gnt;
    logic [PV-1:0] tail;
    logic          cfg_wr;
    logic [2:0]    cfg_port;
    logic [3:0]    cfg_weight;
    logic [P-1:0]  iport;
    logic [PV-1:0] vcw;
    logic          rs;

    int errors = 0;
    int checks = 0;

    swa_weight_ctrl #(.P(P), .V(V), .WEIGHTw(4), .INIT_WEIGHT(1)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .ivc_request_all              (req),
        .ivc_num_getting_sw_grant     (gnt),
        .granted_flit_is_tail_all     (tail),
        .cfg_wr                       (cfg_wr),
        .cfg_port                     (cfg_port),
        .cfg_weight                   (cfg_weight),
        .iport_weight_is_consumed_all (iport),
        .vc_weight_is_consumed_all    (vcw),
        .round_start                  (rs)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [PV-1:0] r, input logic [PV-1:0] g, input logic [PV-1:0] t);
        req  = r;
        gnt  = g;
        tail = t;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cfg_wr = 1'b0; cfg_port = '0; cfg_weight = '0;
        drive('0, '0, '0);
        repeat (2) step();
        reset = 1'b1;
        #1;
    endtask

    task automatic write_cfg(input logic [2:0] port, input logic [3:0] w);
        cfg_wr = 1'b1; cfg_port = port; cfg_weight = w;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cfg_wr = 1'b0; cfg_port = '0; cfg_weight = '0;
        drive(B0, '0, '0);
        step();
        checks++; if (iport !== 5'b0) begin errors++; $display("FAIL reset_iport: got %b want %b", iport, 5'b0); end
        checks++; if (vcw !== 20'h0) begin errors++; $display("FAIL reset_vc: got %h want %h", vcw, 20'h0); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL reset_round_start: got %b want 0", rs); end
        do_reset();
    endtask

    task automatic test_weight_update();
        do_reset();
        write_cfg(3'd0, 4'd3);
        drive(B0, B0, '0);
        checks++; if (iport[0] !== 1'b0) begin errors++; $display("FAIL wu_pre_flag: got %b want 0", iport[0]); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL wu_pre_rs: got %b want 0", rs); end
        step();
        checks++; if (iport[0] !== 1'b1) begin errors++; $display("FAIL wu_r1_port: got %b want 1", iport[0]); end
        checks++; if (vcw[0] !== 1'b1) begin errors++; $display("FAIL wu_r1_vc: got %b want 1", vcw[0]); end
        checks++; if (rs !== 1'b1) begin errors++; $display("FAIL wu_r1_rs: got %b want 1", rs); end
        step();
        checks++; if (iport[0] !== 1'b0) begin errors++; $display("FAIL wu_r2_g1: got %b want 0", iport[0]); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL wu_r2_g1_rs: got %b want 0", rs); end
        step();
        checks++; if (iport[0] !== 1'b0) begin errors++; $display("FAIL wu_r2_g2: got %b want 0", iport[0]); end
        step();
        checks++; if (iport[0] !== 1'b1) begin errors++; $display("FAIL wu_r2_g3: got %b want 1", iport[0]); end
        checks++; if (vcw[0] !== 1'b1) begin errors++; $display("FAIL wu_r2_vc: got %b want 1", vcw[0]); end
        checks++; if (rs !== 1'b1) begin errors++; $display("FAIL wu_r2_rs: got %b want 1", rs); end
    endtask

    task automatic test_two_ports();
        do_reset();
        write_cfg(3'd1, 4'd2);
        write_cfg(3'd2, 4'd2);
        drive(B0, B0, '0);
        step();
        drive(B0, '0, '0);
        checks++; if (rs !== 1'b1) begin errors++; $display("FAIL tp_load_rs: got %b want 1", rs); end
        step();
        drive(B4 | B8, B4, '0);
        checks++; if (iport !== 5'b0) begin errors++; $display("FAIL tp_c4_iport: got %b want %b", iport, 5'b0); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL tp_c4_rs: got %b want 0", rs); end
        step();
        drive(B4 | B8, B8, '0);
        checks++; if (iport !== 5'b0) begin errors++; $display("FAIL tp_c5_iport: got %b want %b", iport, 5'b0); end
        step();
        drive(B4 | B8, B4, '0);
        checks++; if (iport !== 5'b0) begin errors++; $display("FAIL tp_c6_iport: got %b want %b", iport, 5'b0); end
        step();
        drive(B4 | B8, B8, '0);
        checks++; if (iport !== 5'b00010) begin errors++; $display("FAIL tp_c7_iport: got %b want %b", iport, 5'b00010); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL tp_c7_rs: got %b want 0", rs); end
        step();
        drive(B4 | B8, '0, '0);
        checks++; if (iport !== 5'b00110) begin errors++; $display("FAIL tp_c8_iport: got %b want %b", iport, 5'b00110); end
        checks++; if (vcw !== (B4 | B8)) begin errors++; $display("FAIL tp_c8_vc: got %h want %h", vcw, B4 | B8); end
        checks++; if (rs !== 1'b1) begin errors++; $display("FAIL tp_c8_rs: got %b want 1", rs); end
        step();
        checks++; if (iport !== 5'b0) begin errors++; $display("FAIL tp_c9_iport: got %b want %b", iport, 5'b0); end
        checks++; if (vcw !== 20'h0) begin errors++; $display("FAIL tp_c9_vc: got %h want %h", vcw, 20'h0); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL tp_c9_rs: got %b want 0", rs); end
    endtask

    task automatic test_tail();
        do_reset();
        write_cfg(3'd1, 4'd4);
        drive(B0, B0, '0);
        step();
        drive(B0, '0, '0);
        step();
        drive(B5, B5, '0);
        checks++; if (vcw[5] !== 1'b0) begin errors++; $display("FAIL tail_g0_vc: got %b want 0", vcw[5]); end
        step();
        drive(B5, B5, B5);
        checks++; if (vcw[5] !== 1'b0) begin errors++; $display("FAIL tail_g1_vc: got %b want 0", vcw[5]); end
        step();
        drive(B5, '0, '0);
        checks++; if (vcw[5] !== 1'b1) begin errors++; $display("FAIL tail_g2_vc: got %b want 1", vcw[5]); end
        checks++; if (iport[1] !== 1'b0) begin errors++; $display("FAIL tail_g2_port: got %b want 0", iport[1]); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL tail_g2_rs: got %b want 0", rs); end
    endtask

    task automatic test_restart_grant();
        do_reset();
        drive(B0, B0, '0);
        step();
        checks++; if (rs !== 1'b1) begin errors++; $display("FAIL rg_rs: got %b want 1", rs); end
        step();
        drive(B0, '0, '0);
        checks++; if (iport[0] !== 1'b1) begin errors++; $display("FAIL rg_port: got %b want 1", iport[0]); end
        checks++; if (vcw[0] !== 1'b1) begin errors++; $display("FAIL rg_vc: got %b want 1", vcw[0]); end
        checks++; if (rs !== 1'b1) begin errors++; $display("FAIL rg_rs2: got %b want 1", rs); end
        step();
        checks++; if (iport[0] !== 1'b0) begin errors++; $display("FAIL rg_clear_port: got %b want 0", iport[0]); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL rg_clear_rs: got %b want 0", rs); end
    endtask

    task automatic test_idle_hold();
        do_reset();
        write_cfg(3'd1, 4'd3);
        write_cfg(3'd0, 4'd0);
        drive(B0, B0, '0);
        step();
        drive(B0, '0, '0);
        step();
        drive(B0 | B4, B0 | B4, '0);
        step();
        drive(B0 | B4, B4, '0);
        checks++; if (iport !== 5'b00001) begin errors++; $display("FAIL idle_zero_weight: got %b want %b", iport, 5'b00001); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL idle_partial_rs: got %b want 0", rs); end
        step();
        drive('0, '0, '0);
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL idle_norq_rs: got %b want 0", rs); end
        step();
        step();
        checks++; if (iport !== 5'b00001) begin errors++; $display("FAIL idle_hold_iport: got %b want %b", iport, 5'b00001); end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL idle_hold_rs: got %b want 0", rs); end
        drive(B0, '0, '0);
        checks++; if (rs !== 1'b1) begin errors++; $display("FAIL idle_resume_rs: got %b want 1", rs); end
        drive(B4, B4, '0);
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL idle_resume_p1_rs: got %b want 0", rs); end
        step();
        drive(B4, '0, '0);
        checks++; if (iport !== 5'b00011) begin errors++; $display("FAIL idle_held_count: got %b want %b", iport, 5'b00011); end
        checks++; if (rs !== 1'b1) begin errors++; $display("FAIL idle_final_rs: got %b want 1", rs); end
    endtask

    task automatic test_async_reset();
        do_reset();
        write_cfg(3'd0, 4'd3);
        drive(B0, B0, '0);
        step();
        drive(B0, '0, '0);
        step();
        drive(B0 | B4, B0 | B4, '0);
        step();
        drive(B0 | B4, B0, '0);
        cfg_wr = 1'b1; cfg_port = 3'd0; cfg_weight = 4'd7;
        step();
        cfg_wr = 1'b0;
        drive(B0 | B4, '0, '0);
        checks++; if (iport !== 5'b00010) begin errors++; $display("FAIL ar_pre_iport: got %b want %b", iport, 5'b00010); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (iport !== 5'b0) begin errors++; $display("FAIL ar_async_iport: got %b want %b", iport, 5'b0); end
        checks++; if (vcw !== 20'h0) begin errors++; $display("FAIL ar_async_vc: got %h want %h", vcw, 20'h0); end
        drive('0, '0, '0);
        repeat (2) step();
        reset = 1'b1;
        drive(B0, B0, '0);
        step();
        drive(B0, '0, '0);
        checks++; if (iport !== 5'b00001) begin errors++; $display("FAIL ar_init_weight: got %b want %b", iport, 5'b00001); end
        checks++; if (rs !== 1'b1) begin errors++; $display("FAIL ar_init_rs: got %b want 1", rs); end
    endtask

    initial begin
        reset = 1'b0;
        cfg_wr = 1'b0; cfg_port = '0; cfg_weight = '0;
        req = '0; gnt = '0; tail = '0;
        test_reset();
        test_weight_update();
        test_two_ports();
        test_tail();
        test_restart_grant();
        test_idle_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/swa_weight_ctrl.md
# swa_weight_ctrl

Weighted-round-robin budget controller for the combined VC/switch allocator. It tracks how many switch grants each input port and each input VC have won in the current arbitration round. It drives the `iport_weight_is_consumed_all` and `vc_weight_is_consumed_all` masks that the allocator's first- and second-stage arbiters consume. It also starts a new round once every requesting port has used its budget. It sits in the router next to the allocator, fed by the allocator's own grant outputs.

## Interface
- `P`, 5: number of router ports.
- `V`, 4: VCs per port; PV = P*V.
- `WEIGHTw`, 4: width of weight and counter fields.
- `INIT_WEIGHT`, 1: per-port weight after reset; must be 1..2^WEIGHTw-1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `ivc_request_all`  in  PV  per-IVC switch request, same encoding as the allocator input (bit i = port i/V, VC i%V).
- `ivc_num_getting_sw_grant`  in  PV  one-hot-per-port IVC granted this cycle.
- `granted_flit_is_tail_all`  in  PV  the granted IVC's current flit is a tail (or single-flit packet).
- `cfg_wr`  in  1  weight write strobe.
- `cfg_port`  in  $clog2(P)  port index for the write.
- `cfg_weight`  in  WEIGHTw  new weight; 0 is stored as 1.
- `iport_weight_is_consumed_all`  out  P  port budget used up this round.
- `vc_weight_is_consumed_all`  out  PV  IVC budget used up this round.
- `round_start`  out  1  one-cycle pulse on the cycle a new round begins.

## Operation
- Per port p, the block keeps three registers:
  - `w_act[p]`: the active weight.
  - `w_shd[p]`: the shadow weight.
  - `pcnt[p]`: grants to port p this round, WEIGHTw bits, saturating at `w_act[p]`.
- Per IVC i, the block keeps `vcnt[i]`, WEIGHTw bits, saturating at the owning port's `w_act`.
- Config writes:
  - `cfg_wr` writes `w_shd[cfg_port]` only; `w_act` copies all of `w_shd` at a round restart.
  - Weights therefore never change mid-round.
  - If `cfg_port` >= P, the write is ignored.
- Port grant: a port is granted when any bit of port p's slice of `ivc_num_getting_sw_grant` is set.
  - `pcnt[p]` increments by 1.
  - `iport_weight_is_consumed_all[p]` is the registered flag `pcnt[p] == w_act[p]`.
- IVC grant: when IVC i is granted, `vcnt[i]` increments.
  - Flag i sets when `vcnt[i]` reaches `w_act[p]`, or when the granted flit is a tail.
  - Packet boundary ends the IVC's turn.
  - The flag stays set until restart.
- Round done condition (combinational from registered state): for every port p, either the port flag is set or p has no request (`ivc_request_all` slice all 0). It also requires at least one port flag to be set.
- Round restart, taken at the edge that ends the cycle in which round done is true:
  - all `pcnt` and `vcnt` are cleared;
  - all flags are cleared;
  - `w_act` is loaded from `w_shd`;
  - `round_start` = 1 in that cycle.
- Grant during the restart cycle: it is counted in the new round, so `pcnt` = 1 and `vcnt` = 1 after the edge. Flags set immediately if the new weight is 1 or the granted flit is a tail.
- Grants to an already-consumed port or IVC are counted (saturating) and do not clear flags. The block never blocks traffic itself; the allocator masks on the flags.
- No requests anywhere: round done is false and the state holds. This avoids spurious restarts on an idle router.

## Timing
- Reset (`reset` = 0, asynchronous):
  - `w_act` = `w_shd` = INIT_WEIGHT;
  - all counters = 0;
  - both flag outputs = 0;
  - `round_start` = 0.
- Reset release is synchronous to the next `clk` edge. Reset mid-round discards all counts and shadow writes.
- Grant in cycle t → flag visible in cycle t+1 (one-cycle latency; no combinational grant-to-flag path).
- `round_start` is combinational from registers (flags, `ivc_request_all`) and is valid in the restart cycle. Flags read 0 in cycle t+1 after it.
- A `cfg_wr` in the same cycle as a restart is captured into `w_shd` but not into `w_act`; it takes effect at the following restart.
- Counter arithmetic is saturating, with no wrap-around at 2^WEIGHTw-1.

## Test plan
- Reset, then `cfg_wr` with port 0 and weight 3. Port 0 VC0 requests alone and is granted every cycle. Required response:
  - port flag stays 0 until the cycle after the 1st grant;
  - round 1 uses weight 1, so port 0 VC0's flag is 1 after 1 grant;
  - restart pulses;
  - the next round needs 3 grants before `iport_weight_is_consumed_all[0]` = 1.
- Ports 1 and 2 have weight 2 and both request continuously, granted alternately. Required response:
  - no `round_start` until both flags = 1, i.e. after 4 grants total;
  - `round_start` in that cycle;
  - flags 0 the next cycle.
- Weight 4, IVC 5 granted with a tail flit on its 2nd grant. Required response: `vc_weight_is_consumed_all[5]` = 1 after the 2nd grant, while the port flag stays 0.
- A grant arrives in the restart cycle with weight 1. Required response: after the edge, `pcnt` = 1 and the port flag = 1, with no lost grant.
- All requests drop to 0 with partial counts. Required response:
  - no `round_start`, counters held;
  - when requests resume on a consumed port only, a restart follows in that cycle.
- Assert `reset` = 0 asynchronously mid-round with counts 2/3 and a pending shadow write of 7. Required response: outputs go to 0 immediately, and after release `w_act` = INIT_WEIGHT.
